// File: rtl/uart_byte_rx_pkg.sv
// uart_pkg: shared FSM states, default bit period and frame-header bytes for the UART receiver and parser
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam logic [7:0] HDR_0 = 8'h2E;
  localparam logic [7:0] HDR_1 = 8'h16;
  localparam logic [7:0] HDR_2 = 8'hD2;
  localparam logic [7:0] HDR_3 = 8'h04;
endpackage

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial line in, byte strobe and error strobes out
// master = receiver (reads rx_i, drives data_o/valid_o/frame_err_o/parity_err_o); slave = line source / byte consumer
interface uart_byte_rx_if;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       parity_err_o;
  modport master(input rx_i, output data_o, valid_o, frame_err_o, parity_err_o);
  modport slave(output rx_i, input data_o, valid_o, frame_err_o, parity_err_o);
endinterface

// File: rtl/uart_bit_sync.sv
// uart_bit_sync: STAGES-deep synchronizer, resets to 1 (idle line)
// ports: clk, rst (async active-low), i_d async input, o_q synchronized output
module uart_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_q <= '1;
    else      r_q <= {r_q[STAGES-2:0], i_d};
  assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver producing one byte strobe per frame; UART_RX_PARITY_EN adds even parity
// ports: clk, rst (async active-low), bus (uart_byte_rx_if.master: rx_i in; data_o, valid_o, frame_err_o, parity_err_o out)
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input logic            clk,
  input logic            rst,
  uart_byte_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TH = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TF = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  logic          w_rx;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_perr;
  logic          r_pbad;
  uart_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(bus.rx_i),
    .o_q(w_rx)
  );
  // Counter free-runs by default; every terminal (and IDLE/BREAK) clears it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_pbad  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_cnt   <= r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rx) r_state <= START;
        end
        START: if (r_cnt == TH) begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_state <= w_rx ? IDLE : DATA;
        end
        DATA: if (r_cnt == TF) begin
          r_cnt <= '0;
          r_sh  <= {w_rx, r_sh[7:1]};
          r_idx <= r_idx + 1'b1;
          if (r_idx == 3'd7) r_state <= AFTER_DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (r_cnt == TF) begin
          r_cnt   <= '0;
          r_pbad  <= w_rx ^ (^r_sh);
          r_state <= STOP;
        end
`endif
        STOP: if (r_cnt == TF) begin
          r_cnt   <= '0;
          r_ferr  <= !w_rx;
          r_state <= w_rx ? IDLE : BREAK;
`ifdef UART_RX_PARITY_EN
          r_perr  <= w_rx && r_pbad;
          r_valid <= w_rx && !r_pbad;
          if (w_rx && !r_pbad) r_data <= r_sh;
`else
          r_valid <= w_rx;
          if (w_rx) r_data <= r_sh;
`endif
        end
        BREAK: begin
          r_cnt <= '0;
          if (w_rx) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.data_o       = r_data;
  assign bus.valid_o      = r_valid;
  assign bus.frame_err_o  = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err_o = r_perr;
`else
  assign bus.parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx with a frame-level line model
module tb_uart_byte_rx;
  import uart_pkg::*;
  localparam int C = 16;
  localparam int S = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int NB = PEN ? 11 : 10;
  typedef struct {
    int         kind;
    logic [7:0] d;
    int         cyc;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t q[$];
  logic [7:0] last_good = 8'h00;
  uart_byte_rx_if bus();
  uart_byte_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // A frame's strobe appears one clock after its stop-bit mid-sample:
  // sync delay + half a bit + (NB-1) full bits + 1.
  task automatic send(input logic [7:0] b, input logic stop, input logic flip);
    logic [11:0] f;
    ev_t e;
    f = PEN ? {1'b1, stop, (^b) ^ flip, b, 1'b0} : {2'b11, stop, b, 1'b0};
    e.kind = !stop ? 1 : ((PEN && flip) ? 2 : 0);
    e.d    = (e.kind == 0) ? b : last_good;
    e.cyc  = cyc + S + C / 2 + (NB - 1) * C + 1;
    if (e.kind == 0) last_good = b;
    q.push_back(e);
    for (int i = 0; i < NB; i++) begin
      bus.rx_i = f[i];
      repeat (C) @(negedge clk);
    end
  endtask
  always @(negedge clk)
    if (rst && (bus.valid_o || bus.frame_err_o || bus.parity_err_o)) begin
      int k;
      ev_t e;
      k = bus.valid_o ? 0 : (bus.frame_err_o ? 1 : 2);
      chk("excl", int'(bus.valid_o) + int'(bus.frame_err_o) + int'(bus.parity_err_o), 1);
      if (q.size() == 0) chk("unexpected", k, -1);
      else begin
        e = q.pop_front();
        chk("kind", k, e.kind);
        chk("data", bus.data_o, e.d);
        chk("time", cyc, e.cyc);
      end
    end
  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [11:0] f;
    bus.rx_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_ferr", bus.frame_err_o, 0);
    chk("rst_perr", bus.parity_err_o, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send(HDR_0, 1'b1, 1'b0);
    repeat (2 * C) @(negedge clk);
    send(HDR_0, 1'b1, 1'b0);
    send(HDR_1, 1'b1, 1'b0);
    send(HDR_2, 1'b1, 1'b0);
    send(HDR_3, 1'b1, 1'b0);
    repeat (C) @(negedge clk);
    bus.rx_i = 1'b0;
    repeat (5) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (2 * C) @(negedge clk);
    send(8'hA5, 1'b1, 1'b0);
    repeat (C) @(negedge clk);
    send(8'h00, 1'b0, 1'b0);
    repeat (40 * C) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (C) @(negedge clk);
    send(8'h5A, 1'b1, 1'b0);
    repeat (C) @(negedge clk);
    f = {4'hF, 8'hFF} << 1;
    for (int i = 0; i < 5; i++) begin
      bus.rx_i = f[i];
      repeat (C) @(negedge clk);
    end
    bus.rx_i = 1'b1;
    repeat (C / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_data", bus.data_o, 0);
    chk("mid_rst_valid", bus.valid_o, 0);
    chk("mid_rst_ferr", bus.frame_err_o, 0);
    chk("mid_rst_perr", bus.parity_err_o, 0);
    last_good = 8'h00;
    rst = 1'b1;
    repeat (12 * C) @(negedge clk);
    send(8'h3C, 1'b1, 1'b0);
    repeat (C) @(negedge clk);
    if (PEN) begin
      send(8'h07, 1'b1, 1'b0);
      send(8'h07, 1'b1, 1'b1);
      repeat (C) @(negedge clk);
    end
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send(b, !bad, PEN && ($urandom_range(0, 4) == 0));
      if (bad) begin
        repeat ($urandom_range(1, 3 * C)) @(negedge clk);
        bus.rx_i = 1'b1;
        repeat ($urandom_range(4, 2 * C)) @(negedge clk);
      end else
        repeat ($urandom_range(0, C)) @(negedge clk);
    end
    for (int t = 0; t < 20 * C && q.size() != 0; t++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial-to-byte UART receiver: 8 data bits, LSB first, 1 stop bit, no parity by default.
- Sits directly upstream of the streaming frame parser and drives its byte/valid inputs.
- Output is one byte per frame, marked by a one-cycle strobe; the parser samples it on the next clock.
- The parser's downstream path (FIFO, then FFT input) is unaffected.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- SYNC_STAGES, 2: synchronizer depth on rx_i; legal range 2..4.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_i  input  1  asynchronous serial line; idles high.
- data_o  output  8  last correctly received byte; held until the next good byte.
- valid_o  output  1  one-cycle strobe: data_o is new this cycle.
- frame_err_o  output  1  one-cycle strobe: stop bit sampled low.
- parity_err_o  output  1  one-cycle strobe: parity mismatch. Tied 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset (rst low, asynchronous):
  - data_o=0x00, valid_o=0, frame_err_o=0, parity_err_o=0.
  - Synchronizer flops set to 1 (line idle). State=IDLE, counters=0, shift register=0x00.
- rx_i passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Bit counter: width $clog2(CLKS_PER_BIT). Runs from 0 to its terminal value, where the sample is taken, then returns to 0.
- IDLE: when rx_s==0, go to START with counter cleared.
- START: terminal value is CLKS_PER_BIT/2-1 (integer division).
  - At terminal, if rx_s==0: go to DATA, bit_idx=0.
  - At terminal, if rx_s==1: treat as a glitch and return to IDLE with no strobe.
- DATA: terminal value is CLKS_PER_BIT-1.
  - At each terminal, shift rx_s into the MSB of an 8-bit shift-right register, then increment the 3-bit bit_idx.
  - After the 8th sample (bit_idx wrapping 7 to 0), go to STOP, or to PARITY when the macro is enabled.
- STOP: terminal value is CLKS_PER_BIT-1.
  - rx_s==1: in the next cycle data_o=shift register and valid_o=1 for exactly one cycle; go to IDLE.
  - rx_s==0: in the next cycle frame_err_o=1 for one cycle; data_o unchanged; go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line therefore produces one frame_err_o pulse, not a pulse per frame time.
- Latency: valid_o rises 1 clk after the stop-bit mid-sample. That point is SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk after the start-bit falling edge reaches rx_i.
- Back-to-back frames: a start bit that falls immediately after the stop-bit sample is accepted. Returning to IDLE at mid-stop allows zero idle time between frames.
- valid_o and frame_err_o are never high in the same cycle.
- No backpressure: the downstream stage must accept every strobe. Receiver throughput is limited by the line rate.
- Reset mid-frame: the partial byte is discarded, with no strobe before or after release of reset.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; even parity; sampled at counter terminal CLKS_PER_BIT-1.
  - On a parity mismatch, the frame still completes through STOP.
  - If the stop bit is high, parity_err_o=1 for one cycle, replacing valid_o. data_o is not updated.
  - If the stop bit is low, only frame_err_o pulses.
- Not defined: no PARITY state; parity_err_o tied to 0.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Default CLKS_PER_BIT constant.
  - Frame-header byte constants 0x2E, 0x16, 0xD2, 0x04, also used by the parser.
- One sub-module: uart_bit_sync, a SYNC_STAGES-deep flop chain with async active-low reset and reset value 1.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2, ideal line timing unless stated):
- Send 0x2E with 1 stop bit -> exactly one valid_o pulse with data_o=0x2E, at the latency formula; no error strobes.
- Send 0x2E, 0x16, 0xD2, 0x04 with zero idle between frames -> four valid_o pulses in order, each 160 clk apart.
- 5-cycle low glitch on an idle line -> no strobes; state back in IDLE; a following 0xA5 is received correctly.
- Send 0x00 with the stop bit low, then hold the line low for 40 bit times, then release -> one frame_err_o pulse, no valid_o, data_o keeps its prior value; a following 0x5A is received.
- Assert rst during bit 4 of 0xFF, release, then send 0x3C -> all outputs 0 during reset, no strobe for the partial byte, one valid_o with data_o=0x3C.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> valid_o; send 0x07 with parity bit 0 -> parity_err_o pulse and data_o unchanged.
